// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared pseudo-Mersenne modulus constants for the reduction and modular-add stages
package mod_pkg;

    localparam int MOD_W = 32;
    localparam int MOD_C = 5;
    localparam logic [MOD_W-1:0] MOD = {MOD_W{1'b1}} - MOD_W'(MOD_C - 1);
    localparam int T1_BW = MOD_W + $clog2(MOD_C + 1);
    localparam int T2_BW = MOD_W + 1;

endpackage

// File: rtl/mod_fold.sv
// rtl/mod_fold.sv - combinational lo + C*hi fold using 2^LO_W == C (mod 2^LO_W - C)
module mod_fold #(
    parameter int IN_W  = 64,
    parameter int LO_W  = 32,
    parameter int C     = 5,
    parameter int OUT_W = 35
) (
    input  logic [IN_W-1:0]  in_val,
    output logic [OUT_W-1:0] out_val
);

    logic [OUT_W-1:0] lo_ext;
    logic [OUT_W-1:0] hi_ext;

    always_comb begin
        lo_ext  = OUT_W'(in_val[LO_W-1:0]);
        hi_ext  = OUT_W'(in_val[IN_W-1:LO_W]);
        out_val = lo_ext + OUT_W'(C) * hi_ext;
    end

endmodule

// File: rtl/mod_reduce_pm.sv
// rtl/mod_reduce_pm.sv - 3-stage pseudo-Mersenne reduction of a 2W-bit product to [0, MOD)
// Optional MOD_REDUCE_STATS_EN adds output-transfer and stall-cycle counters.
module mod_reduce_pm
    import mod_pkg::*;
#(
    parameter int W = MOD_W,
    parameter int C = MOD_C
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [2*W-1:0] X,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
`ifdef MOD_REDUCE_STATS_EN
    output logic [W-1:0]   Z,
    output logic [31:0]    STAT_OUT_CNT,
    output logic [31:0]    STAT_STALL_CNT
`else
    output logic [W-1:0]   Z
`endif
);

    localparam int T1W = W + $clog2(C + 1);
    localparam int T2W = W + 1;
    localparam logic [W-1:0] MOD_L = {W{1'b1}} - W'(C - 1);

    logic           v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [T1W-1:0] t1_q, t1_d, s1_out;
    logic [T2W-1:0] t2_q, t2_d, s2_out;
    logic [W-1:0]   z_q, z_d, z_corr;
    logic           adv1, adv2, adv3;

    mod_fold #(.IN_W(2*W), .LO_W(W), .C(C), .OUT_W(T1W)) u_fold_s1 (
        .in_val  (X),
        .out_val (s1_out)
    );

    mod_fold #(.IN_W(T1W), .LO_W(W), .C(C), .OUT_W(T2W)) u_fold_s2 (
        .in_val  (t1_q),
        .out_val (s2_out)
    );

    // Ready ripples back from the consumer so bubbles collapse even while stalled.
    always_comb begin
        adv3   = !v3_q || OUT_READY;
        adv2   = !v2_q || adv3;
        adv1   = !v1_q || adv2;
        z_corr = (t2_q >= {1'b0, MOD_L}) ? W'(t2_q - {1'b0, MOD_L}) : t2_q[W-1:0];

        v1_d = adv1 ? IN_VALID : v1_q;
        v2_d = adv2 ? v1_q     : v2_q;
        v3_d = adv3 ? v2_q     : v3_q;
        t1_d = (adv1 && IN_VALID) ? s1_out : t1_q;
        t2_d = (adv2 && v1_q)     ? s2_out : t2_q;
        z_d  = (adv3 && v2_q)     ? z_corr : z_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            t1_q <= '0;
            t2_q <= '0;
            z_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            t1_q <= t1_d;
            t2_q <= t2_d;
            z_q  <= z_d;
        end
    end

    assign IN_READY  = adv1;
    assign OUT_VALID = v3_q;
    assign Z         = z_q;

`ifdef MOD_REDUCE_STATS_EN
    logic [31:0] out_cnt_q, out_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        out_cnt_d   = out_cnt_q + 32'(v3_q && OUT_READY);
        stall_cnt_d = stall_cnt_q + 32'(v3_q && !OUT_READY);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_cnt_q   <= out_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STAT_OUT_CNT   = out_cnt_q;
    assign STAT_STALL_CNT = stall_cnt_q;
`endif

endmodule
